// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: coprocessor-0 registers, Count/Compare timer and prioritised interrupt controller.
module cp0_irq_ctrl #(
  parameter int          NUM_IRQ  = 5,
  parameter int          PC_W     = 30,
  parameter int          TIMER_EN = 1,
  parameter logic [31:0] PRID     = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc,
  input  logic [31:0]        din,
  input  logic [NUM_IRQ-1:0] hw_int,
  input  logic [4:0]         sel,
  input  logic               wr,
  input  logic               exl_set,
  input  logic               exl_clr,
  output logic               irq,
  output logic [PC_W-1:0]    epc,
  output logic [31:0]        dout
);
  localparam int L = NUM_IRQ + 1;

  logic [31:0]        count, compare;
  logic               ie, exl, timer_pend;
  logic [L-1:0]       im, ip, pend;
  logic [NUM_IRQ-1:0] ip_hw, hw_prev, edge_cfg, rise, clr;
  logic [2:0]         irqid, irqid_n;
  logic               w_count, w_compare, w_sr, w_cause, w_epc, w_edge;

  assign w_count   = wr && sel == 5'd9;
  assign w_compare = wr && sel == 5'd11;
  assign w_sr      = wr && sel == 5'd12;
  assign w_cause   = wr && sel == 5'd13;
  assign w_epc     = wr && sel == 5'd14;
  assign w_edge    = wr && sel == 5'd16;

  assign ip   = {timer_pend, ip_hw};
  assign pend = ip & im;
  assign irq  = ie && !exl && |pend;
  assign rise = hw_int & ~hw_prev;
  assign clr  = w_cause ? din[10 +: NUM_IRQ] : '0;

  // Ascending scan so the highest pending index is the one left standing.
  always_comb begin
    irqid_n = '0;
    for (int i = 0; i < L; i++)
      if (pend[i]) irqid_n = 3'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      compare    <= '1;
      ie         <= 1'b0;
      exl        <= 1'b0;
      im         <= '0;
      ip_hw      <= '0;
      hw_prev    <= '0;
      edge_cfg   <= '0;
      timer_pend <= 1'b0;
      irqid      <= '0;
      epc        <= '0;
    end else begin
      count      <= w_count ? din : count + 32'd1;
      compare    <= w_compare ? din : compare;
      timer_pend <= w_compare ? 1'b0 : ((TIMER_EN != 0 && count == compare) ? 1'b1 : timer_pend);
      hw_prev    <= hw_int;
      ip_hw      <= (edge_cfg & (rise | (ip_hw & ~clr))) | (~edge_cfg & hw_int);
      edge_cfg   <= w_edge ? din[NUM_IRQ-1:0] : edge_cfg;
      ie         <= w_sr ? din[0] : ie;
      im         <= w_sr ? din[10 +: L] : im;
      exl        <= exl_set ? 1'b1 : w_sr ? din[1] : exl_clr ? 1'b0 : exl;
      epc        <= exl_set ? pc : w_epc ? din[PC_W+1:2] : epc;
      irqid      <= exl_set ? irqid_n : irqid;
    end
  end

  always_comb begin
    dout = '0;
    case (sel)
      5'd9:  dout = count;
      5'd11: dout = compare;
      5'd12: begin
        dout[0]      = ie;
        dout[1]      = exl;
        dout[10 +: L] = im;
      end
      5'd13: begin
        dout[10 +: L] = ip;
        dout[20:18]   = irqid;
      end
      5'd14: dout[PC_W+1:0] = {epc, 2'b00};
      5'd15: dout = PRID;
      5'd16: dout[NUM_IRQ-1:0] = edge_cfg;
      default: dout = '0;
    endcase
  end
endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// tb_cp0_irq_ctrl: directed and randomized checks of cp0_irq_ctrl against a behavioural CP0 model.
module tb_cp0_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] pc = '0;
  logic [31:0] din = '0;
  logic [4:0]  hw_int = '0;
  logic [4:0]  sel = '0;
  logic        wr = 1'b0, exl_set = 1'b0, exl_clr = 1'b0;
  logic        irq;
  logic [29:0] epc;
  logic [31:0] dout;

  int n_chk = 0, n_fail = 0;

  logic [31:0] m_count, m_compare;
  logic        m_ie, m_exl;
  logic [5:0]  m_im, m_ip;
  logic [2:0]  m_irqid;
  logic [29:0] m_epc;
  logic [4:0]  m_edge, m_prev;

  cp0_irq_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc), .din(din), .hw_int(hw_int), .sel(sel),
    .wr(wr), .exl_set(exl_set), .exl_clr(exl_clr), .irq(irq), .epc(epc), .dout(dout)
  );

  always #10 clk = ~clk;

  task automatic m_reset();
    m_count = 0; m_compare = 32'hFFFF_FFFF; m_ie = 0; m_exl = 0; m_im = 0; m_ip = 0;
    m_irqid = 0; m_epc = 0; m_edge = 0; m_prev = 0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] s);
    logic [31:0] r;
    r = 0;
    if (s == 5'd9) r = m_count;
    else if (s == 5'd11) r = m_compare;
    else if (s == 5'd12) begin r[0] = m_ie; r[1] = m_exl; r[15:10] = m_im; end
    else if (s == 5'd13) begin r[15:10] = m_ip; r[20:18] = m_irqid; end
    else if (s == 5'd14) r = {m_epc, 2'b00};
    else if (s == 5'd15) r = 32'h0000_0100;
    else if (s == 5'd16) r[4:0] = m_edge;
    return r;
  endfunction

  function automatic logic m_irq();
    return m_ie && !m_exl && ((m_ip & m_im) != 0);
  endfunction

  // One clock: apply inputs, advance the model by the architectural rules, settle past the edge.
  task automatic step(input logic w, input logic [4:0] s, input logic [31:0] d, input logic es, input logic ec);
    logic [31:0] n_count, n_compare;
    logic        n_ie, n_exl;
    logic [5:0]  n_im, n_ip;
    logic [2:0]  n_irqid;
    logic [29:0] n_epc;
    logic [4:0]  n_edge;
    wr = w; sel = s; din = d; exl_set = es; exl_clr = ec;
    n_count = (w && s == 9) ? d : m_count + 1;
    n_compare = (w && s == 11) ? d : m_compare;
    n_ip = m_ip;
    if (w && s == 11) n_ip[5] = 0;
    else if (m_count == m_compare) n_ip[5] = 1;
    for (int i = 0; i < 5; i++) begin
      if (!m_edge[i]) n_ip[i] = hw_int[i];
      else if (hw_int[i] && !m_prev[i]) n_ip[i] = 1;
      else if (w && s == 13 && d[10+i]) n_ip[i] = 0;
    end
    n_ie = (w && s == 12) ? d[0] : m_ie;
    n_im = (w && s == 12) ? d[15:10] : m_im;
    n_exl = es ? 1'b1 : (w && s == 12) ? d[1] : ec ? 1'b0 : m_exl;
    n_epc = es ? pc : (w && s == 14) ? d[31:2] : m_epc;
    n_irqid = m_irqid;
    if (es) begin
      n_irqid = 0;
      for (int i = 5; i >= 0; i--)
        if (m_ip[i] && m_im[i]) begin n_irqid = 3'(i); break; end
    end
    n_edge = (w && s == 16) ? d[4:0] : m_edge;
    @(posedge clk);
    m_count = n_count; m_compare = n_compare; m_ip = n_ip; m_ie = n_ie; m_im = n_im;
    m_exl = n_exl; m_epc = n_epc; m_irqid = n_irqid; m_edge = n_edge; m_prev = hw_int;
    #1;
    wr = 0; exl_set = 0; exl_clr = 0;
  endtask

  task automatic test_reset();
    logic [4:0] sl[9] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3, 5'd0};
    logic [31:0] ex[9] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0};
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    m_reset();
    for (int k = 0; k < 9; k++) begin
      sel = sl[k]; #1;
      n_chk++;
      if (dout !== ex[k]) begin n_fail++; $display("FAIL reset_sel%0d got=%h exp=%h", sl[k], dout, ex[k]); end
    end
    n_chk++;
    if (irq !== 1'b0 || epc !== 30'h0) begin n_fail++; $display("FAIL reset_out irq=%b epc=%h exp 0/0", irq, epc); end
    rst = 1;
    step(0, 0, 0, 0, 0);
    sel = 9; #1;
    n_chk++;
    if (dout !== 32'd1) begin n_fail++; $display("FAIL reset_count1 got=%h exp=1", dout); end
  endtask

  task automatic test_level();
    step(1, 12, 32'h0000_0401, 0, 0);
    hw_int = 5'b00001;
    step(0, 0, 0, 0, 0);
    sel = 13; #1;
    n_chk++;
    if (dout !== mread(13) || irq !== 1'b1) begin n_fail++; $display("FAIL level_rise cause=%h irq=%b exp=%h/1", dout, irq, mread(13)); end
    hw_int = 0;
    step(0, 0, 0, 0, 0);
    n_chk++;
    if (irq !== m_irq() || irq !== 1'b0) begin n_fail++; $display("FAIL level_drop irq=%b exp=0", irq); end
    step(1, 12, 32'h0000_0001, 0, 0);
    hw_int = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0);
      n_chk++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL level_masked irq=%b exp=0", irq); end
    end
    hw_int = 0;
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_edge_w1c();
    step(1, 16, 32'h2, 0, 0);
    step(1, 12, 32'h0000_0801, 0, 0);
    hw_int = 5'b00010;
    step(0, 0, 0, 0, 0);
    hw_int = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    sel = 13; #1;
    n_chk++;
    if (dout[11] !== 1'b1 || dout !== mread(13) || irq !== 1'b1) begin n_fail++; $display("FAIL edge_hold cause=%h irq=%b exp=%h/1", dout, irq, mread(13)); end
    step(1, 13, 32'h800, 0, 0);
    sel = 13; #1;
    n_chk++;
    if (dout[11] !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL edge_clear cause=%h irq=%b exp ip11=0", dout, irq); end
    hw_int = 5'b00010;
    step(1, 13, 32'h800, 0, 0);
    hw_int = 0;
    sel = 13; #1;
    n_chk++;
    if (dout[11] !== 1'b1 || dout !== mread(13)) begin n_fail++; $display("FAIL edge_set_wins cause=%h exp=%h", dout, mread(13)); end
    step(1, 13, 32'h800, 0, 0);
  endtask

  task automatic test_timer();
    step(1, 11, 32'd20, 0, 0);
    step(1, 9, 32'd10, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0, 0, 0);
      sel = 13; #1;
      n_chk++;
      if (dout !== mread(13)) begin n_fail++; $display("FAIL timer_walk%0d cause=%h exp=%h", k, dout, mread(13)); end
    end
    n_chk++;
    if (dout[15] !== 1'b1) begin n_fail++; $display("FAIL timer_set ip15=%b exp=1", dout[15]); end
    step(1, 11, 32'h8000_0000, 0, 0);
    sel = 13; #1;
    n_chk++;
    if (dout[15] !== 1'b0) begin n_fail++; $display("FAIL timer_clear ip15=%b exp=0", dout[15]); end
    step(1, 9, 32'hFFFF_FFFE, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    sel = 9; #1;
    n_chk++;
    if (dout !== 32'h0 || dout !== mread(9)) begin n_fail++; $display("FAIL timer_wrap count=%h exp=0", dout); end
  endtask

  task automatic test_priority();
    hw_int = 5'b01001;
    pc = 30'h0C00;
    step(1, 12, 32'h0000_FC01, 0, 0);
    step(1, 11, m_count + 2, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL prio_pending irq=%b exp=1", irq); end
    step(0, 0, 0, 1, 0);
    sel = 14; #1;
    n_chk++;
    if (dout !== 32'h0000_3000 || epc !== 30'h0C00) begin n_fail++; $display("FAIL prio_epc dout=%h epc=%h exp=00003000", dout, epc); end
    sel = 13; #1;
    n_chk++;
    if (dout[20:18] !== 3'd5 || dout !== mread(13)) begin n_fail++; $display("FAIL prio_irqid cause=%h exp=%h", dout, mread(13)); end
    sel = 12; #1;
    n_chk++;
    if (dout[1] !== 1'b1 || irq !== 1'b0) begin n_fail++; $display("FAIL prio_exl sr=%h irq=%b exp exl=1 irq=0", dout, irq); end
    step(0, 0, 0, 0, 1);
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL prio_eret irq=%b exp=1", irq); end
    hw_int = 0;
  endtask

  task automatic test_conflicts();
    step(0, 0, 0, 1, 1);
    sel = 12; #1;
    n_chk++;
    if (dout[1] !== 1'b1) begin n_fail++; $display("FAIL conf_set_clr exl=%b exp=1", dout[1]); end
    step(0, 0, 0, 0, 1);
    step(1, 12, 32'h0, 1, 0);
    sel = 12; #1;
    n_chk++;
    if (dout !== 32'h2) begin n_fail++; $display("FAIL conf_set_sr sr=%h exp=00000002", dout); end
    pc = 30'h0ABC;
    step(1, 14, 32'h1234, 1, 0);
    sel = 14; #1;
    n_chk++;
    if (dout !== 32'h0000_2AF0 || epc !== 30'h0ABC) begin n_fail++; $display("FAIL conf_set_epc dout=%h epc=%h exp=00002af0", dout, epc); end
    step(1, 12, 32'h2, 0, 1);
    sel = 12; #1;
    n_chk++;
    if (dout[1] !== 1'b1) begin n_fail++; $display("FAIL conf_sr_clr exl=%b exp=1", dout[1]); end
  endtask

  task automatic test_random();
    logic [4:0] sl[8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd16, 5'd3, 5'd15};
    logic [4:0] s;
    for (int k = 0; k < 400; k++) begin
      hw_int = 5'($urandom);
      pc = 30'($urandom);
      s = sl[$urandom_range(0, 7)];
      step(($urandom % 3) == 0, s, $urandom, ($urandom % 6) == 0, ($urandom % 5) == 0);
      sel = sl[$urandom_range(0, 7)]; #1;
      n_chk++;
      if (dout !== mread(sel) || irq !== m_irq() || epc !== m_epc) begin
        n_fail++;
        $display("FAIL rand%0d sel=%0d dout=%h exp=%h irq=%b exp=%b epc=%h exp=%h", k, sel, dout, mread(sel), irq, m_irq(), epc, m_epc);
      end
    end
    hw_int = 0;
  endtask

  task automatic test_midreset();
    step(1, 12, 32'h0000_FC03, 0, 0);
    rst = 0; #1;
    m_reset();
    sel = 9; #1;
    n_chk++;
    if (dout !== 32'h0 || irq !== 1'b0 || epc !== 30'h0) begin n_fail++; $display("FAIL midreset count=%h irq=%b epc=%h exp 0", dout, irq, epc); end
    sel = 12; #1;
    n_chk++;
    if (dout !== 32'h0) begin n_fail++; $display("FAIL midreset_sr sr=%h exp=0", dout); end
    @(posedge clk); #1;
    rst = 1;
    step(0, 0, 0, 0, 0);
    sel = 9; #1;
    n_chk++;
    if (dout !== 32'd1) begin n_fail++; $display("FAIL midreset_count1 got=%h exp=1", dout); end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_w1c();
    test_timer();
    test_priority();
    test_conflicts();
    test_random();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
